// File: rtl/mc_pkg.sv
// mc_pkg -- shared encodings for the multi-cycle controller.
// Holds the FSM state type, next-PC / write-address / write-data / ALU
// select encodings, the opcode and funct constants of the supported
// instructions, and the one-hot instruction class with small helpers
// that group class bits into the categories the controller branches on.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] WA_RT = 2'd0;
  localparam logic [1:0] WA_RD = 2'd1;
  localparam logic [1:0] WA_RA = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MEM   = 2'd1;
  localparam logic [1:0] WD_PC    = 2'd2;
  localparam logic [1:0] WD_SHIFT = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_XOR = 6'h26;

  // Bit positions of the one-hot instruction class; all-zero means NOP.
  localparam int CLS_ADD = 0;
  localparam int CLS_SUB = 1;
  localparam int CLS_XOR = 2;
  localparam int CLS_SLL = 3;
  localparam int CLS_JR  = 4;
  localparam int CLS_ORI = 5;
  localparam int CLS_LUI = 6;
  localparam int CLS_LW  = 7;
  localparam int CLS_SW  = 8;
  localparam int CLS_LB  = 9;
  localparam int CLS_SB  = 10;
  localparam int CLS_BEQ = 11;
  localparam int CLS_BNE = 12;
  localparam int CLS_J   = 13;
  localparam int CLS_JAL = 14;
  localparam int CLS_W   = 15;

  typedef logic [CLS_W-1:0] cls_t;

  function automatic logic is_load(input cls_t c);
    return c[CLS_LW] | c[CLS_LB];
  endfunction

  function automatic logic is_store(input cls_t c);
    return c[CLS_SW] | c[CLS_SB];
  endfunction

  function automatic logic is_mem(input cls_t c);
    return is_load(c) | is_store(c);
  endfunction

  function automatic logic is_branch(input cls_t c);
    return c[CLS_BEQ] | c[CLS_BNE];
  endfunction

  function automatic logic is_jump(input cls_t c);
    return c[CLS_J] | c[CLS_JAL] | c[CLS_JR];
  endfunction

  function automatic logic is_rtype(input cls_t c);
    return c[CLS_ADD] | c[CLS_SUB] | c[CLS_XOR] | c[CLS_SLL] | c[CLS_JR];
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode -- combinational instruction classifier.
// Ports:
//   opcode  in  6   IR[31:26]
//   funct   in  6   IR[5:0], only meaningful for R-type
//   cls     out 15  one-hot instruction class, all-zero for unsupported
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls
);

  // Any opcode/funct pair not listed falls through with cls still zero,
  // which the controller treats as a NOP.
  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  cls[CLS_ADD] = 1'b1;
          FN_SUB:  cls[CLS_SUB] = 1'b1;
          FN_XOR:  cls[CLS_XOR] = 1'b1;
          FN_SLL:  cls[CLS_SLL] = 1'b1;
          FN_JR:   cls[CLS_JR]  = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls[CLS_ORI] = 1'b1;
      OP_LUI:  cls[CLS_LUI] = 1'b1;
      OP_LW:   cls[CLS_LW]  = 1'b1;
      OP_SW:   cls[CLS_SW]  = 1'b1;
      OP_LB:   cls[CLS_LB]  = 1'b1;
      OP_SB:   cls[CLS_SB]  = 1'b1;
      OP_BEQ:  cls[CLS_BEQ] = 1'b1;
      OP_BNE:  cls[CLS_BNE] = 1'b1;
      OP_J:    cls[CLS_J]   = 1'b1;
      OP_JAL:  cls[CLS_JAL] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl -- five-state multi-cycle controller (FETCH/DECODE/EXEC/MEM/WB).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   opcode, funct           instruction fields, valid from DECODE onward
//   cmp_eq                  rs==rt from the datapath, used in EXEC
//   mem_ready               memory finishes the current access this cycle
//   mem_req/mem_write/byte_en   memory access controls
//   ir_write/pc_write/reg_write strobes; pc_src/wa_src/wd_src selects
//   alu_src/alu_sel/ext_sel     ALU and immediate controls
//   state                   current FSM state (debug)
//   retire                  pulse in the last cycle of each instruction
// Outputs are combinational from the state and class registers because
// the FETCH/MEM handshake and the branch decision must act in the same
// cycle that mem_ready / cmp_eq arrive.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       cmp_eq,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       byte_en,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] wa_src,
  output logic [1:0] wd_src,
  output logic       alu_src,
  output logic [2:0] alu_sel,
  output logic       ext_sel,
  output logic [2:0] state,
  output logic       retire
);

  state_t state_q;
  state_t state_d;
  cls_t   dec_cls;
  cls_t   cls_q;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (dec_cls)
  );

  // State and class registers. The class is captured at the end of DECODE
  // so that EXEC/MEM/WB no longer depend on the IR fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= dec_cls;
    end
  end

  // Next-state and output logic. DECODE looks at the live decoder output
  // since the class register is only loaded at the end of that cycle.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    byte_en   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    reg_write = 1'b0;
    wa_src    = WA_RT;
    wd_src    = WD_ALU;
    alu_src   = 1'b0;
    alu_sel   = ALU_ADD;
    ext_sel   = 1'b0;
    retire    = 1'b0;

    // ALU controls are held stable for the whole EXEC..WB span so the
    // computed address / result stays valid across memory stalls.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_src = is_mem(cls_q) | cls_q[CLS_ORI] | cls_q[CLS_LUI];
      ext_sel = cls_q[CLS_ORI] | cls_q[CLS_LUI];
      if (cls_q[CLS_SUB] | is_branch(cls_q)) alu_sel = ALU_SUB;
      else if (cls_q[CLS_ORI])               alu_sel = ALU_OR;
      else if (cls_q[CLS_LUI])               alu_sel = ALU_LUI;
      else if (cls_q[CLS_XOR])               alu_sel = ALU_XOR;
      else                                   alu_sel = ALU_ADD;
    end

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_PLUS4;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        if (dec_cls[CLS_J] | dec_cls[CLS_JAL]) begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
        end
        if (dec_cls[CLS_JAL]) begin
          reg_write = 1'b1;
          wa_src    = WA_RA;
          wd_src    = WD_PC;
        end
        if (dec_cls[CLS_JR]) begin
          pc_write = 1'b1;
          pc_src   = PC_RS;
        end
        // Jumps and unsupported encodings finish here.
        if (is_jump(dec_cls) || dec_cls == '0) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_branch(cls_q)) begin
          pc_write = cls_q[CLS_BEQ] ? cmp_eq : !cmp_eq;
          pc_src   = PC_BRANCH;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_mem(cls_q)) begin
          state_d = S_MEM;
        end else if (is_jump(cls_q) || cls_q == '0) begin
          // Unreachable for a well-formed class; recover to FETCH.
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        mem_req   = 1'b1;
        mem_write = is_store(cls_q);
        byte_en   = cls_q[CLS_LB] | cls_q[CLS_SB];
        if (mem_ready) begin
          if (is_store(cls_q)) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        wa_src    = is_rtype(cls_q) ? WA_RD : WA_RT;
        if (is_load(cls_q))      wd_src = WD_MEM;
        else if (cls_q[CLS_SLL]) wd_src = WD_SHIFT;
        else                     wd_src = WD_ALU;
        state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    // A reset cycle must not disturb memory, PC, IR or register file,
    // even when it lands in the middle of a stalled access.
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      byte_en   = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

  assign state = state_q;

endmodule
